point_store_arb: RTL and testbench

Owns the N_PTS-entry point coordinate store (x, y) for the tour solver. After reset it fills the store from the external random stream. It then shares the store between N_REQ requesters (cost evaluator, tour mutator, display scanner) through round-robin arbitration, serving one read or write per cycle.

---
 rtl/point_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/point_store_arb.sv | 170 +++++++++++++++++
 tb/tb_point_store_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/point_pkg.sv
// Shared types and defaults for the point coordinate store.
// The optional REGEN_EN build adds a regenerate input to point_store_arb.
package point_pkg;

    localparam int N_PTS_DEF   = 64;
    localparam int COORD_W_DEF = 8;

    // One stored point at the default coordinate width.
    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
    } point_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from a
// rotating pointer; the pointer moves past the winner when upd_en is high.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         upd_en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;
    logic         found;
    int           k;

    // Pick the first requester at or after ptr, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found      = 1'b1;
                gnt[k]     = 1'b1;
                gnt_idx    = W'(k);
            end
        end
    end

    // Advance the pointer to just past the granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (upd_en && (|gnt)) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + W'(1);
        end
    end

endmodule

// File: rtl/point_store_arb.sv
// Point coordinate store for the tour solver. Fills itself from the random
// stream after reset, then serves one read or write per cycle to N_REQ
// requesters under round-robin arbitration. Reads return data one cycle
// after the grant on the shared rx/ry bus with a one-hot rvalid pulse.
// Build option REGEN_EN adds a regen input that refills the store on demand.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | writing entry cnt from rnd_val each cycle, grants blocked
//   ST_SERVE | store filled, arbitrating requester reads/writes
module point_store_arb
    import point_pkg::*;
#(
    parameter int N_PTS   = N_PTS_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int N_REQ   = 2,
    parameter int IDX_W   = $clog2(N_PTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              rnd_val,
`ifdef REGEN_EN
    input  logic                     regen,
`endif
    output logic                     init_done,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*IDX_W-1:0]   idx,
    input  logic [N_REQ*COORD_W-1:0] wx,
    input  logic [N_REQ*COORD_W-1:0] wy,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [COORD_W-1:0]       rx,
    output logic [COORD_W-1:0]       ry
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Same layout as point_t, sized by this instance's COORD_W.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pt_t;

    st_t              state, state_n;
    logic [IDX_W-1:0] cnt, cnt_n;
    pt_t              store [N_PTS];

    logic             serve;
    logic             regen_hit;
    logic [N_REQ-1:0] arb_req;
    logic [SEL_W-1:0] sel;
    logic             xfer;
    logic             sel_we;
    logic [IDX_W-1:0] sel_idx;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    pt_t              wr_pt;

    generate
        if (2 * COORD_W < 32) begin : g_rnd_spare
            logic unused_rnd;
            assign unused_rnd = ^rnd_val[31:2*COORD_W];
        end
    endgenerate

    assign serve     = (state == ST_SERVE);
    assign init_done = serve;

`ifdef REGEN_EN
    assign regen_hit = regen && serve;
`else
    assign regen_hit = 1'b0;
`endif

    // No grants while filling or in the cycle a refill is requested.
    assign arb_req = (serve && !regen_hit) ? req : '0;

    rr_arbiter #(
        .N (N_REQ),
        .W (SEL_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .upd_en  (serve),
        .gnt     (gnt),
        .gnt_idx (sel)
    );

    assign xfer    = |(req & gnt);
    assign sel_we  = we[sel];
    assign sel_idx = idx[int'(sel)*IDX_W +: IDX_W];

    // State and fill counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: fill walks every entry once, then serve until refill.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_INIT: begin
                cnt_n = cnt + IDX_W'(1);
                if (cnt == IDX_W'(N_PTS - 1)) begin
                    state_n = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (regen_hit) begin
                    state_n = ST_INIT;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_INIT;
                cnt_n   = '0;
            end
        endcase
    end

    // Single write port shared by the fill sequence and requester writes.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = cnt;
        wr_pt.x  = rnd_val[COORD_W-1:0];
        wr_pt.y  = rnd_val[2*COORD_W-1:COORD_W];
        if (state == ST_INIT) begin
            wr_en = 1'b1;
        end else if (xfer && sel_we) begin
            wr_en   = 1'b1;
            wr_idx  = sel_idx;
            wr_pt.x = wx[int'(sel)*COORD_W +: COORD_W];
            wr_pt.y = wy[int'(sel)*COORD_W +: COORD_W];
        end
    end

    // Store array; contents are meaningless until the fill completes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_idx] <= wr_pt;
        end
    end

    // Read data register: rvalid pulses for one cycle, rx/ry hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= '0;
            rx     <= '0;
            ry     <= '0;
        end else begin
            rvalid <= '0;
            if (xfer && !sel_we) begin
                rvalid <= gnt;
                rx     <= store[sel_idx].x;
                ry     <= store[sel_idx].y;
            end
        end
    end

endmodule

// File: tb/tb_point_store_arb.sv
// Directed bench for point_store_arb (2 requesters, 64 points, 8-bit coords).
module tb_point_store_arb;
    import point_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rnd_val;
    logic        regen = 1'b0;
    logic        init_done;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [11:0] idx = '0;
    logic [15:0] wx = '0;
    logic [15:0] wy = '0;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rx;
    logic [7:0]  ry;

    int          errors = 0;
    int          checks = 0;
    int          fill_i = 0;
    logic [7:0]  rnd_base = 8'h00;

    always #5 clk = ~clk;

    // Random stream stand-in: fill cycle i sees {i+1+base, i+base}.
    always @(posedge clk) begin
        if (rst || regen) fill_i <= 0;
        else              fill_i <= fill_i + 1;
    end
    assign rnd_val = {16'h0, 8'(fill_i + 1) + rnd_base, 8'(fill_i) + rnd_base};

    point_store_arb dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_val   (rnd_val),
`ifdef REGEN_EN
        .regen     (regen),
`endif
        .init_done (init_done),
        .req       (req),
        .we        (we),
        .idx       (idx),
        .wx        (wx),
        .wy        (wy),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rx        (rx),
        .ry        (ry)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        int bad = 0;
        while (!init_done && n < 200) begin
            if (gnt != 2'b00) bad++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_gnt_in_init"}, 32'(bad), 32'd0);
        chk({tag, "_fill_cycles"}, 32'(n), 32'(N_PTS_DEF));
    endtask

    task automatic do_read(input int k, input logic [5:0] i, input logic [7:0] ex, input logic [7:0] ey);
        int n = 0;
        logic [1:0] e;
        e = 2'b01 << k;
        idx[k*6 +: 6] = i;
        we[k]  = 1'b0;
        req[k] = 1'b1;
        #1;
        while (!gnt[k] && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_gnt_seen", 32'(gnt[k]), 32'd1);
        @(posedge clk); #1;
        req[k] = 1'b0;
        chk("rd_rvalid", 32'(rvalid), 32'(e));
        chk("rd_rx", 32'(rx), 32'(ex));
        chk("rd_ry", 32'(ry), 32'(ey));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rx", 32'(rx), 32'd0);
        chk("rst_ry", 32'(ry), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Requester 0 holds a read of idx 5 through the whole fill
        req = 2'b01;
        we  = 2'b00;
        idx[5:0] = 6'd5;
        rst = 1'b0;
        wait_init("fill");
        chk("first_serve_gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        req = 2'b00;
        chk("fill_rvalid", 32'(rvalid), 32'h1);
        chk("fill_rx", 32'(rx), 32'h05);
        chk("fill_ry", 32'(ry), 32'h06);
        @(posedge clk); #1;
        chk("pulse_rvalid", 32'(rvalid), 32'h0);
        chk("hold_rx", 32'(rx), 32'h05);

        // Round robin: last grant went to 0, so 1 wins first
        req = 2'b11;
        idx = {6'd7, 6'd3};
        begin
            logic [1:0] exp_g;
            exp_g = 2'b10;
            #1;
            for (int j = 0; j < 4; j++) begin
                chk("rr_gnt", 32'(gnt), 32'(exp_g));
                @(posedge clk); #1;
                chk("rr_rvalid", 32'(rvalid), 32'(exp_g));
                chk("rr_rx", 32'(rx), exp_g[0] ? 32'd3 : 32'd7);
                chk("rr_ry", 32'(ry), exp_g[0] ? 32'd4 : 32'd8);
                exp_g = {exp_g[0], exp_g[1]};
            end
        end
        req = 2'b00;

        // Write by requester 1, then read of the same entry by requester 0
        req = 2'b10;
        we  = 2'b10;
        idx[11:6] = 6'd10;
        wx[15:8] = 8'h3C;
        wy[15:8] = 8'hA5;
        #1;
        chk("wr_gnt", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        req = 2'b01;
        we  = 2'b00;
        idx[5:0] = 6'd10;
        #1;
        chk("wtr_gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        chk("wtr_rvalid", 32'(rvalid), 32'h1);
        chk("wtr_rx", 32'(rx), 32'h3C);
        chk("wtr_ry", 32'(ry), 32'hA5);
        chk("lone_gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        chk("lone_rvalid", 32'(rvalid), 32'h1);
        req = 2'b00;

        // Reset in the cycle of a read grant, refill with a new stream
        req = 2'b01;
        idx[5:0] = 6'd20;
        #1;
        chk("rst_op_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        rnd_base = 8'h40;
        @(posedge clk); #1;
        chk("rst_op_rvalid", 32'(rvalid), 32'h0);
        chk("rst_op_init_done", 32'(init_done), 32'h0);
        rst = 1'b0;
        req = 2'b00;
        wait_init("refill");
        do_read(0, 6'd20, 8'h54, 8'h55);
        do_read(1, 6'd63, 8'h7F, 8'h80);
        do_read(0, 6'd10, 8'h4A, 8'h4B);

`ifdef REGEN_EN
        // Read grant, then regen while requester 1 asks
        req = 2'b01;
        idx[5:0] = 6'd4;
        #1;
        chk("pre_regen_gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        req = 2'b10;
        idx[11:6] = 6'd1;
        regen = 1'b1;
        rnd_base = 8'h80;
        #1;
        chk("regen_gnt", 32'(gnt), 32'h0);
        chk("regen_prev_rvalid", 32'(rvalid), 32'h1);
        chk("regen_prev_rx", 32'(rx), 32'h44);
        @(posedge clk); #1;
        regen = 1'b0;
        req = 2'b00;
        chk("regen_init_done", 32'(init_done), 32'h0);
        chk("regen_rvalid", 32'(rvalid), 32'h0);
        wait_init("regen");
        do_read(1, 6'd2, 8'h82, 8'h83);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
